pixel_timing_gen: RTL and testbench

//  Parametrised frame/line timing sequencer for the image pipeline: generates VSYNC, HSYNC, DE,

---
 rtl/pixel_timing_pkg.sv | 28 ++
 rtl/pixel_timing_gen.sv | 149 ++++++++++++++
 tb/tb_pixel_timing_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_timing_pkg.sv
// Shared state encoding and parameter helpers for the pixel timing sequencer
// and the image_read/image_write blocks that follow its timing.
package pixel_timing_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_VBLANK = 3'd1;
   localparam logic [2:0] ST_ACTIVE = 3'd2;
   localparam logic [2:0] ST_HBLANK = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   function automatic bit params_legal(input int img_w, input int img_h,
                                       input int ppc, input int v_blank);
      return (ppc == 1 || ppc == 2) && (img_w > 0) && (img_h > 0) &&
             (img_w % ppc == 0) && (v_blank >= 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width of a counter running 0..limit-1, never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/pixel_timing_gen.sv
// Frame/line timing sequencer: VSYNC/HSYNC/DE, X/Y coordinates and frame count
// from a single start pulse, with blanking, multi-pixel beats, multi-frame runs and stall.
module pixel_timing_gen
   import pixel_timing_pkg::*;
#(
   parameter int IMG_W   = 768,
   parameter int IMG_H   = 512,
   parameter int PPC     = 2,
   parameter int H_BLANK = 160,
   parameter int V_BLANK = 20,
   parameter int FRAMES  = 1,
   parameter int CNT_W   = 16
)(
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic             stall,
   output logic             VSYNC,
   output logic             HSYNC,
   output logic             DE,
   output logic [CNT_W-1:0] X,
   output logic [CNT_W-1:0] Y,
   output logic [15:0]      FRAME_CNT,
   output logic             busy,
   output logic             ctrl_done
);

   localparam int BEATS = IMG_W / PPC;
   localparam int PH_W  = cnt_width(max3(V_BLANK, H_BLANK, BEATS));

   localparam logic [PH_W-1:0]  V_LAST = PH_W'(V_BLANK - 1);
   localparam logic [PH_W-1:0]  B_LAST = PH_W'(BEATS - 1);
   localparam logic [PH_W-1:0]  H_LAST = PH_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] X_STEP = CNT_W'(PPC);
   localparam logic [15:0]      F_LAST = 16'(FRAMES);

   if (!params_legal(IMG_W, IMG_H, PPC, V_BLANK)) begin : g_bad_params
      $fatal(1, "pixel_timing_gen: illegal IMG_W/IMG_H/PPC/V_BLANK combination");
   end

   logic [2:0]       state_reg, state_next;
   logic [PH_W-1:0]  phase_reg, phase_next;
   logic [CNT_W-1:0] x_reg, x_next;
   logic [CNT_W-1:0] y_reg, y_next;
   logic [15:0]      frame_reg, frame_next;
   logic             vsync_reg, active_reg, busy_reg, done_reg;

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      frame_next = frame_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = ST_VBLANK;
               phase_next = '0;
               x_next     = '0;
               y_next     = '0;
               frame_next = '0;
            end
         end
         ST_VBLANK: begin
            if (!stall) begin
               if (phase_reg == V_LAST) begin
                  state_next = ST_ACTIVE;
                  phase_next = '0;
               end else begin
                  phase_next = phase_reg + PH_W'(1);
               end
            end
         end
         ST_ACTIVE: begin
            if (!stall) begin
               if (phase_reg == B_LAST) begin
                  phase_next = '0;
                  x_next     = '0;
                  if (y_reg == Y_LAST) begin
                     // Final line goes straight to VBLANK/DONE, never through HBLANK.
                     y_next     = '0;
                     frame_next = frame_reg + 16'd1;
                     if (FRAMES != 0 && frame_next == F_LAST)
                        state_next = ST_DONE;
                     else
                        state_next = ST_VBLANK;
                  end else if (H_BLANK == 0) begin
                     y_next = y_reg + CNT_W'(1);
                  end else begin
                     state_next = ST_HBLANK;
                  end
               end else begin
                  phase_next = phase_reg + PH_W'(1);
                  x_next     = x_reg + X_STEP;
               end
            end
         end
         ST_HBLANK: begin
            if (!stall) begin
               if (phase_reg == H_LAST) begin
                  state_next = ST_ACTIVE;
                  phase_next = '0;
                  y_next     = y_reg + CNT_W'(1);
               end else begin
                  phase_next = phase_reg + PH_W'(1);
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg  <= ST_IDLE;
         phase_reg  <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         frame_reg  <= '0;
         vsync_reg  <= 1'b0;
         active_reg <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         phase_reg  <= phase_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         frame_reg  <= frame_next;
         vsync_reg  <= (state_next == ST_VBLANK);
         active_reg <= (state_next == ST_ACTIVE);
         busy_reg   <= (state_next == ST_VBLANK) || (state_next == ST_ACTIVE) ||
                       (state_next == ST_HBLANK);
         done_reg   <= (state_next == ST_DONE);
      end
   end

   // A stalled cycle emits no beat, so the strobe is masked in the same cycle.
   assign HSYNC     = active_reg & ~stall;
   assign DE        = HSYNC;
   assign VSYNC     = vsync_reg;
   assign X         = x_reg;
   assign Y         = y_reg;
   assign FRAME_CNT = frame_reg;
   assign busy      = busy_reg;
   assign ctrl_done = done_reg;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench for pixel_timing_gen: frame timeline, stall, PPC=2 back-to-back lines,
// start filtering, mid-frame reset and a long free-running run.
`timescale 1ns/1ps
module tb_pixel_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut: IMG 4x2, PPC=1, H_BLANK=2, V_BLANK=3, FRAMES=2
   logic a_start = 1'b0, a_stall = 1'b0;
   logic a_vs, a_hs, a_de, a_busy, a_done;
   logic [15:0] a_x, a_y, a_fc;

   // dut3: PPC=2, H_BLANK=0, FRAMES=1
   logic b_start = 1'b0, b_stall = 1'b0;
   logic b_vs, b_hs, b_de, b_busy, b_done;
   logic [15:0] b_x, b_y, b_fc;

   // dut6: free-run
   logic c_start = 1'b0, c_stall = 1'b0;
   logic c_vs, c_hs, c_de, c_busy, c_done;
   logic [15:0] c_x, c_y, c_fc;

   pixel_timing_gen #(.IMG_W(4), .IMG_H(2), .PPC(1), .H_BLANK(2), .V_BLANK(3),
                      .FRAMES(2), .CNT_W(16)) dut (
      .HCLK(clk), .HRESETn(rst_n), .start(a_start), .stall(a_stall),
      .VSYNC(a_vs), .HSYNC(a_hs), .DE(a_de), .X(a_x), .Y(a_y),
      .FRAME_CNT(a_fc), .busy(a_busy), .ctrl_done(a_done));

   pixel_timing_gen #(.IMG_W(4), .IMG_H(2), .PPC(2), .H_BLANK(0), .V_BLANK(3),
                      .FRAMES(1), .CNT_W(16)) dut3 (
      .HCLK(clk), .HRESETn(rst_n), .start(b_start), .stall(b_stall),
      .VSYNC(b_vs), .HSYNC(b_hs), .DE(b_de), .X(b_x), .Y(b_y),
      .FRAME_CNT(b_fc), .busy(b_busy), .ctrl_done(b_done));

   pixel_timing_gen #(.IMG_W(4), .IMG_H(2), .PPC(1), .H_BLANK(2), .V_BLANK(3),
                      .FRAMES(0), .CNT_W(16)) dut6 (
      .HCLK(clk), .HRESETn(rst_n), .start(c_start), .stall(c_stall),
      .VSYNC(c_vs), .HSYNC(c_hs), .DE(c_de), .X(c_x), .Y(c_y),
      .FRAME_CNT(c_fc), .busy(c_busy), .ctrl_done(c_done));

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Hand-derived timeline of dut with start in cycle 0 and no stall.
   task automatic exp_t1(input int c, output int vs, output int hs, output int x,
                         output int y, output int fc, output int bz, output int dn);
      vs = ((c >= 1 && c <= 3) || (c >= 14 && c <= 16)) ? 1 : 0;
      hs = 0; x = 0; y = 0;
      if (c >= 4 && c <= 7)        begin hs = 1; x = c - 4;  end
      else if (c >= 10 && c <= 13) begin hs = 1; x = c - 10; y = 1; end
      else if (c >= 17 && c <= 20) begin hs = 1; x = c - 17; end
      else if (c >= 23 && c <= 26) begin hs = 1; x = c - 23; y = 1; end
      fc = (c >= 27) ? 2 : (c >= 14) ? 1 : 0;
      bz = (c >= 1 && c <= 26) ? 1 : 0;
      dn = (c >= 27) ? 1 : 0;
   endtask

   task automatic check_a(input string t, input int vs, input int hs, input int x,
                          input int y, input int fc, input int bz, input int dn);
      check_eq({t, " VSYNC"}, a_vs, vs);
      check_eq({t, " HSYNC"}, a_hs, hs);
      check_eq({t, " DE"}, a_de, hs);
      check_eq({t, " X"}, a_x, x);
      check_eq({t, " Y"}, a_y, y);
      check_eq({t, " FRAME_CNT"}, a_fc, fc);
      check_eq({t, " busy"}, a_busy, bz);
      check_eq({t, " ctrl_done"}, a_done, dn);
   endtask

   // Leaves the bench 1ns after a rising edge: that cycle is "cycle 0".
   task automatic apply_reset();
      rst_n = 1'b0;
      a_start = 0; a_stall = 0; b_start = 0; b_stall = 0; c_start = 0; c_stall = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vs, hs, x, y, fc, bz, dn;
      bit busy_dropped, done_seen;

      // Test 1 + 4: reset state, two-frame timeline, start ignored while ACTIVE.
      apply_reset();
      @(negedge clk);
      check_a("reset", 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      for (int c = 0; c <= 28; c++) begin
         a_start = (c == 0 || c == 5);
         @(negedge clk);
         exp_t1(c, vs, hs, x, y, fc, bz, dn);
         check_a($sformatf("t1 c%0d", c), vs, hs, x, y, fc, bz, dn);
         next_cycle();
      end
      a_start = 1'b0;
      $display("t1 two-frame timeline checked, total=%0d", n_total);

      // Test 4: restart from DONE.
      a_start = 1'b1;
      next_cycle();
      a_start = 1'b0;
      @(negedge clk);
      check_a("t4 restart", 1, 0, 0, 0, 0, 1, 0);
      $display("t4 restart from DONE checked, total=%0d", n_total);

      // Test 2: stall in cycles 5..6 (plus a stall coinciding with start in cycle 0).
      apply_reset();
      for (int c = 0; c <= 13; c++) begin
         a_start = (c == 0);
         a_stall = (c == 0 || c == 5 || c == 6);
         @(negedge clk);
         if (c < 5)       exp_t1(c, vs, hs, x, y, fc, bz, dn);
         else if (c <= 6) begin vs = 0; hs = 0; x = 1; y = 0; fc = 0; bz = 1; dn = 0; end
         else             exp_t1(c - 2, vs, hs, x, y, fc, bz, dn);
         check_a($sformatf("t2 c%0d", c), vs, hs, x, y, fc, bz, dn);
         next_cycle();
      end
      a_stall = 1'b0;
      $display("t2 stall timeline checked, total=%0d", n_total);

      // Test 3: PPC=2, H_BLANK=0, single frame.
      apply_reset();
      for (int c = 0; c <= 9; c++) begin
         b_start = (c == 0);
         @(negedge clk);
         vs = (c >= 1 && c <= 3) ? 1 : 0;
         hs = (c >= 4 && c <= 7) ? 1 : 0;
         x  = (c == 5 || c == 7) ? 2 : 0;
         y  = (c == 6 || c == 7) ? 1 : 0;
         fc = (c >= 8) ? 1 : 0;
         bz = (c >= 1 && c <= 7) ? 1 : 0;
         dn = (c >= 8) ? 1 : 0;
         check_eq($sformatf("t3 c%0d VSYNC", c), b_vs, vs);
         check_eq($sformatf("t3 c%0d HSYNC", c), b_hs, hs);
         check_eq($sformatf("t3 c%0d X", c), b_x, x);
         check_eq($sformatf("t3 c%0d Y", c), b_y, y);
         check_eq($sformatf("t3 c%0d FRAME_CNT", c), b_fc, fc);
         check_eq($sformatf("t3 c%0d busy", c), b_busy, bz);
         check_eq($sformatf("t3 c%0d ctrl_done", c), b_done, dn);
         next_cycle();
      end
      b_start = 1'b0;
      $display("t3 PPC=2 back-to-back lines checked, total=%0d", n_total);

      // Test 5: asynchronous reset in cycle 11 (line 1, X=1).
      apply_reset();
      a_start = 1'b1;
      next_cycle();
      a_start = 1'b0;
      repeat (10) next_cycle();
      check_a("t5 pre-reset c11", 0, 1, 1, 1, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      check_a("t5 in reset", 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         check_a($sformatf("t5 idle %0d", c), 0, 0, 0, 0, 0, 0, 0);
      end
      a_start = 1'b1;
      next_cycle();
      a_start = 1'b0;
      check_a("t5 restart", 1, 0, 0, 0, 0, 1, 0);
      $display("t5 mid-frame reset checked, total=%0d", n_total);

      // Test 6: free-run for 300 frames (frame k completes at cycle 1+13k).
      apply_reset();
      busy_dropped = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c <= 3901; c++) begin
         c_start = (c == 0);
         @(negedge clk);
         if (c >= 1 && !c_busy) busy_dropped = 1'b1;
         if (c_done) done_seen = 1'b1;
         if (c == 3900) check_eq("t6 FRAME_CNT c3900", c_fc, 299);
         if (c == 3901) check_eq("t6 FRAME_CNT c3901", c_fc, 300);
         next_cycle();
      end
      c_start = 1'b0;
      check_eq("t6 busy dropped", busy_dropped, 0);
      check_eq("t6 ctrl_done seen", done_seen, 0);
      $display("t6 free-run 300 frames checked, total=%0d", n_total);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
